// File: rtl/arb_deser_pkg.sv
// rtl/arb_deser_pkg.sv - shared state type and constants for the deserializer arbiter
package arb_deser_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT_BUSY,
    WAIT_FREE
  } state_t;

  localparam int BYTE_W       = 8;
  localparam int START_CYCLES = 1;

endpackage

// File: rtl/arbitro_deserializador_rr_arbiter.sv
// rtl/arbitro_deserializador_rr_arbiter.sv - combinational round-robin pick: first request after ptr
module rr_arbiter #(
  parameter  int N_REQ = 4,
  localparam int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    grant_idx,
  output logic             any_req
);

  logic [IW-1:0] cand;
  logic          found;

  // Scan starts one past the last owner, so the last owner is examined last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/arbitro_deserializador.sv
// rtl/arbitro_deserializador.sv - round-robin sequencer feeding one serial deserializer from N_REQ producers
// Optional wait-state abort: ARB_DESER_TIMEOUT_EN
module arbitro_deserializador
  import arb_deser_pkg::*;
#(
  parameter  int N_REQ          = 4,
  parameter  int TIMEOUT_CYCLES = 64,
  localparam int IW             = $clog2(N_REQ)
) (
  input  logic                    clock_100KHz,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    write_in,
  output logic                    data_in,
  input  logic                    status_out,
  output logic [IW-1:0]           grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  state_t            state, state_n;
  logic [2:0]        bit_cnt, bit_cnt_n, bit_nxt;
  logic [BYTE_W-1:0] shift_reg, shift_n;
  logic [IW-1:0]     rr_ptr, rr_ptr_n, grant_id_n;
  logic [N_REQ-1:0]  req_ready_n, arb_grant;
  logic [IW-1:0]     arb_idx;
  logic              arb_any, write_in_n, data_in_n;

  assign bit_nxt = bit_cnt + 3'd1;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_req   (arb_any)
  );

`ifdef ARB_DESER_TIMEOUT_EN
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt, wait_cnt_n;
  logic       timeout_n;
`endif

  // Next-state logic also computes the next value of every registered output.
  always_comb begin
    state_n     = state;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift_reg;
    rr_ptr_n    = rr_ptr;
    grant_id_n  = grant_id;
    req_ready_n = '0;
    write_in_n  = 1'b0;
    data_in_n   = 1'b0;
`ifdef ARB_DESER_TIMEOUT_EN
    wait_cnt_n  = '0;
    timeout_n   = timeout_err;
`endif
    unique case (state)
      IDLE: begin
        if (arb_any && !status_out) begin
          state_n     = START;
          req_ready_n = arb_grant;
          grant_id_n  = arb_idx;
          write_in_n  = 1'b1;
          for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) shift_n = req_data[BYTE_W*i +: BYTE_W];
          end
        end
      end
      START: begin
        state_n    = SHIFT;
        bit_cnt_n  = 3'd0;
        write_in_n = 1'b1;
        data_in_n  = shift_reg[0];
      end
      SHIFT: begin
        if (bit_cnt == 3'd7) begin
          state_n   = WAIT_BUSY;
          bit_cnt_n = 3'd0;
        end else begin
          bit_cnt_n  = bit_nxt;
          write_in_n = 1'b1;
          data_in_n  = shift_reg[bit_nxt];
        end
      end
      WAIT_BUSY: begin
        if (status_out) state_n = WAIT_FREE;
`ifdef ARB_DESER_TIMEOUT_EN
        else if (wait_cnt == WAIT_LAST) begin
          state_n   = IDLE;
          timeout_n = 1'b1;
          rr_ptr_n  = grant_id;
        end else wait_cnt_n = wait_cnt + 8'd1;
`endif
      end
      WAIT_FREE: begin
        if (!status_out) begin
          state_n  = IDLE;
          rr_ptr_n = grant_id;
        end
`ifdef ARB_DESER_TIMEOUT_EN
        else if (wait_cnt == WAIT_LAST) begin
          state_n   = IDLE;
          timeout_n = 1'b1;
          rr_ptr_n  = grant_id;
        end else wait_cnt_n = wait_cnt + 8'd1;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift_reg <= '0;
      rr_ptr    <= IW'(N_REQ - 1);
      grant_id  <= '0;
      req_ready <= '0;
      write_in  <= 1'b0;
      data_in   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      bit_cnt   <= bit_cnt_n;
      shift_reg <= shift_n;
      rr_ptr    <= rr_ptr_n;
      grant_id  <= grant_id_n;
      req_ready <= req_ready_n;
      write_in  <= write_in_n;
      data_in   <= data_in_n;
      busy      <= (state_n != IDLE);
    end
  end

`ifdef ARB_DESER_TIMEOUT_EN
  always_ff @(posedge clock_100KHz) begin
    if (reset) begin
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      wait_cnt    <= wait_cnt_n;
      timeout_err <= timeout_n;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_arbitro_deserializador.sv
// tb/tb_arbitro_deserializador.sv - scoreboard bench for arbitro_deserializador with a behavioural deserializer sink
module tb_arbitro_deserializador;

  typedef logic [7:0] bq_t[$];

  logic        clock_100KHz = 1'b0;
  logic        reset        = 1'b1;
  logic [3:0]  req_valid    = '0;
  logic [31:0] req_data     = '0;
  logic [3:0]  req_ready;
  logic        write_in, data_in, busy, timeout_err;
  logic [1:0]  grant_id;
  logic        status_out   = 1'b0;

  int   n_cmp = 0;
  int   n_bad = 0;
  bq_t  src_q[4];
  bq_t  src_exp[4];
  bq_t  inflight;
  int   exp_grant[$];
  int   grant_cnt[4] = '{0, 0, 0, 0};
  logic [3:0] seen_valid = '0;
  bit   chk_order = 1'b1;
  bit   tog_en    = 1'b0;
  bit   phase     = 1'b0;
  logic ack       = 1'b0;
  bit   auto_ack  = 1'b0;
  logic prev_status = 1'b0;

  int          sk_st   = 0;
  int          sk_cnt  = 0;
  logic [7:0]  sk_sh   = '0;
  logic [7:0]  sk_data = '0;

  arbitro_deserializador #(.N_REQ(4), .TIMEOUT_CYCLES(16)) dut (
    .clock_100KHz (clock_100KHz),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .write_in     (write_in),
    .data_in      (data_in),
    .status_out   (status_out),
    .grant_id     (grant_id),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clock_100KHz = ~clock_100KHz;

  // Deserializer: start cycle, 8 LSB-first bits, busy one cycle later, held until ack.
  always @(posedge clock_100KHz) begin
    case (sk_st)
      0: if (write_in) begin sk_st <= 1; sk_cnt <= 0; end
      1: begin
        if (!write_in) sk_st <= 0;
        else begin
          sk_sh[sk_cnt] <= data_in;
          if (sk_cnt == 7) sk_st <= 2;
          else sk_cnt <= sk_cnt + 1;
        end
      end
      2: begin sk_st <= 3; status_out <= 1'b1; sk_data <= sk_sh; end
      3: if (ack || auto_ack) begin status_out <= 1'b0; sk_st <= 0; end
      default: sk_st <= 0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event not seen within budget or unexpected", name);
  endtask

  task automatic send(input int i, input logic [7:0] b);
    src_q[i].push_back(b);
    src_exp[i].push_back(b);
  endtask

  // Producers: present queue head, drop it once accepted.
  initial begin
    forever begin
      @(posedge clock_100KHz);
      #1;
      seen_valid = req_valid;
      for (int i = 0; i < 4; i++)
        if (req_ready[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
      phase = !phase;
      for (int i = 0; i < 4; i++) begin
        req_valid[i]      = (src_q[i].size() > 0) && !(tog_en && i == 1 && phase);
        req_data[8*i +: 8] = (src_q[i].size() > 0) ? src_q[i][0] : 8'h00;
      end
    end
  end

  // Monitor: grants move expected bytes in flight; sink busy edge retires them.
  initial begin
    int g;
    forever begin
      @(negedge clock_100KHz);
      if (req_ready != 4'b0000) begin
        g = 0;
        for (int i = 3; i >= 0; i--) if (req_ready[i]) g = i;
        check("ready onehot", 32'($onehot(req_ready)), 32'd1);
        check("grant_id", 32'(grant_id), 32'(g));
        check("granted while valid", 32'(seen_valid[g]), 32'd1);
        grant_cnt[g]++;
        if (chk_order) begin
          if (exp_grant.size() == 0) fail_now("grant order (none expected)");
          else check("grant order", 32'(g), 32'(exp_grant.pop_front()));
        end
        if (src_exp[g].size() == 0) fail_now("grant without pending byte");
        else inflight.push_back(src_exp[g].pop_front());
      end
      if (status_out && !prev_status) begin
        if (inflight.size() == 0) fail_now("sink byte (none expected)");
        else check("sink byte", 32'(sk_data), 32'(inflight.pop_front()));
      end
      prev_status = status_out;
    end
  end

  task automatic wait_ready(input string name, input int budget);
    int k = 0;
    do begin @(negedge clock_100KHz); k++; end while (req_ready == 4'b0000 && k < budget);
    if (req_ready == 4'b0000) fail_now(name);
  endtask

  task automatic wait_status(input string name, input logic val, input int budget);
    int k = 0;
    do begin @(negedge clock_100KHz); k++; end while (status_out !== val && k < budget);
    if (status_out !== val) fail_now(name);
  endtask

  task automatic pulse_ack();
    @(posedge clock_100KHz); #1 ack = 1'b1;
    @(posedge clock_100KHz); #1 ack = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clock_100KHz); #1 reset = 1'b1;
    @(posedge clock_100KHz); #1 reset = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int k = 0;
    bit done;
    do begin
      @(negedge clock_100KHz);
      k++;
      done = (inflight.size() == 0) && (exp_grant.size() == 0) && !busy && !status_out;
      for (int i = 0; i < 4; i++) if (src_exp[i].size() != 0) done = 1'b0;
    end while (!done && k < budget);
    if (!done) fail_now(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int t1_seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    bit saw;
    int c1, c3;

    repeat (3) @(negedge clock_100KHz);
    check("rst req_ready", 32'(req_ready), 32'd0);
    check("rst write_in", 32'(write_in), 32'd0);
    check("rst data_in", 32'(data_in), 32'd0);
    check("rst grant_id", 32'(grant_id), 32'd0);
    check("rst busy", 32'(busy), 32'd0);
    check("rst timeout_err", 32'(timeout_err), 32'd0);
    reset = 1'b0;

    // Single byte, ack two cycles after the sink goes busy.
    send(0, 8'hA5); exp_grant.push_back(0);
    wait_ready("t1 grant", 20);
    check("t1 req_ready", 32'(req_ready), 32'h1);
    check("t1 start write_in", 32'(write_in), 32'd1);
    check("t1 start data_in", 32'(data_in), 32'd0);
    for (int b = 0; b < 8; b++) begin
      @(negedge clock_100KHz);
      check("t1 shift write_in", 32'(write_in), 32'd1);
      check("t1 shift data_in", 32'(data_in), 32'(t1_seq[b]));
    end
    @(negedge clock_100KHz);
    check("t1 write_in drops", 32'(write_in), 32'd0);
    @(negedge clock_100KHz);
    check("t1 busy at T+11", 32'(status_out), 32'd1);
    repeat (2) @(posedge clock_100KHz);
    pulse_ack();
    wait_status("t1 sink free", 1'b0, 10);
    repeat (3) @(negedge clock_100KHz);
    check("t1 busy low", 32'(busy), 32'd0);

    // No grant while the sink still holds a byte.
    send(1, 8'h5A); exp_grant.push_back(1);
    wait_status("t3 sink busy", 1'b1, 30);
    send(2, 8'hC3); exp_grant.push_back(2);
    saw = 1'b0;
    repeat (20) begin @(negedge clock_100KHz); if (req_ready != 4'b0000) saw = 1'b1; end
    check("t3 no grant while busy", 32'(saw), 32'd0);
    pulse_ack();
    wait_ready("t3 grant after free", 10);
    check("t3 req_ready", 32'(req_ready), 32'h4);
    wait_status("t3 second busy", 1'b1, 30);
    pulse_ack();
    wait_drain("t3 drain", 50);

    // Ack withheld.
    send(3, 8'h77); exp_grant.push_back(3);
    wait_status("t5 sink busy", 1'b1, 30);
    repeat (40) @(negedge clock_100KHz);
`ifdef ARB_DESER_TIMEOUT_EN
    check("t5 timeout_err", 32'(timeout_err), 32'd1);
    check("t5 busy after abort", 32'(busy), 32'd0);
`else
    check("t5 timeout_err", 32'(timeout_err), 32'd0);
    check("t5 busy held", 32'(busy), 32'd1);
`endif
    pulse_ack();
    wait_drain("t5 drain", 50);

    // Reset in the 4th SHIFT cycle, then a clean transfer.
    auto_ack = 1'b1;
    send(0, 8'h55); exp_grant.push_back(0);
    wait_ready("t4 grant", 20);
    repeat (4) @(negedge clock_100KHz);
    reset = 1'b1;
    @(negedge clock_100KHz);
    check("t4 write_in after reset", 32'(write_in), 32'd0);
    check("t4 busy after reset", 32'(busy), 32'd0);
    check("t4 req_ready after reset", 32'(req_ready), 32'd0);
    reset = 1'b0;
    inflight.delete();
    send(0, 8'h3C); exp_grant.push_back(0);
    wait_drain("t4 drain", 100);

    // All four valid from reset: 0,1,2,3,0.
    do_reset();
    send(0, 8'h11); send(1, 8'h22); send(2, 8'h33); send(3, 8'h44); send(0, 8'h99);
    exp_grant.push_back(0); exp_grant.push_back(1); exp_grant.push_back(2);
    exp_grant.push_back(3); exp_grant.push_back(0);
    wait_drain("t2 drain", 300);

    // req1 toggling against steady req3.
    chk_order = 1'b0;
    tog_en    = 1'b1;
    c1 = grant_cnt[1];
    c3 = grant_cnt[3];
    send(3, 8'hA1); send(3, 8'hA2); send(3, 8'hA3);
    send(1, 8'hB1); send(1, 8'hB2); send(1, 8'hB3);
    wait_drain("t6 drain", 600);
    check("t6 req1 grants", 32'(grant_cnt[1] - c1), 32'd3);
    check("t6 req3 grants", 32'(grant_cnt[3] - c3), 32'd3);

    repeat (2) @(negedge clock_100KHz);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
